// File: rtl/rs_syndrome_seq_if.sv
// Symbol-stream and result handshake bundle for the GF(16) single-error decoder.
interface rs_syndrome_seq_if;
    logic       sym_valid;
    logic [3:0] sym;
    logic       sym_ready;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_status;
    logic [3:0] syn1;
    logic [3:0] syn2;
    logic [3:0] err_pos;
    logic [3:0] err_val;

    modport master (
        output sym_valid, sym, res_ready,
        input  sym_ready, res_valid, res_status, syn1, syn2, err_pos, err_val
    );

    modport slave (
        input  sym_valid, sym, res_ready,
        output sym_ready, res_valid, res_status, syn1, syn2, err_pos, err_val
    );
endinterface

// File: rtl/rs_syndrome_seq.sv
// Reed-Solomon GF(2^4) syndrome accumulator with sequential single-error location search.
module rs_syndrome_seq #(
    parameter int N = 15
) (
    input  logic             clk,
    input  logic             rstn,
    rs_syndrome_seq_if.slave bus
);
    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        EVAL   = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST = 4'(N - 1);

    // Multiply by alpha modulo x^4+x+1: the x^4 term folds back into x+1.
    function automatic logic [3:0] gf_mul2(input logic [3:0] a);
        return {a[2], a[1], a[0] ^ a[3], a[3]};
    endfunction

    function automatic logic [3:0] gf_mul4(input logic [3:0] a);
        return gf_mul2(gf_mul2(a));
    endfunction

    // 0x9 = x^3+1 = alpha^-1, so a*0x9 = a*x^3 ^ a.
    function automatic logic [3:0] gf_mul9(input logic [3:0] a);
        return gf_mul2(gf_mul2(gf_mul2(a))) ^ a;
    endfunction

    state_t     state_r, state_n;
    logic [3:0] s1_r, s1_n;
    logic [3:0] s2_r, s2_n;
    logic [3:0] cnt_r, cnt_n;
    logic [3:0] p_r, p_n;
    logic [3:0] v_r, v_n;
    logic [3:0] k_r, k_n;
    logic [1:0] status_r, status_n;
    logic [3:0] pos_r, pos_n;
    logic [3:0] val_r, val_n;
    logic       sym_ready_r;
    logic       res_valid_r;
    logic [3:0] m2_in_s;
    logic [3:0] m2_out_s;

    // The single x2 multiplier serves S1 during accumulation and P during search.
    always_comb begin
        m2_in_s  = (state_r == SEARCH) ? p_r : s1_r;
        m2_out_s = gf_mul2(m2_in_s);
    end

    // Next-state and datapath update.
    always_comb begin
        state_n  = state_r;
        s1_n     = s1_r;
        s2_n     = s2_r;
        cnt_n    = cnt_r;
        p_n      = p_r;
        v_n      = v_r;
        k_n      = k_r;
        status_n = status_r;
        pos_n    = pos_r;
        val_n    = val_r;
        case (state_r)
            ACCUM: begin
                if (bus.sym_valid) begin
                    s1_n = m2_out_s ^ bus.sym;
                    s2_n = gf_mul4(s2_r) ^ bus.sym;
                    if (cnt_r == LAST) begin
                        cnt_n   = 4'd0;
                        state_n = EVAL;
                    end else begin
                        cnt_n = cnt_r + 4'd1;
                    end
                end else begin
                    state_n = ACCUM;
                end
            end
            EVAL: begin
                if ((s1_r == 4'd0) && (s2_r == 4'd0)) begin
                    status_n = 2'b00;
                    state_n  = DONE;
                end else if ((s1_r == 4'd0) || (s2_r == 4'd0)) begin
                    status_n = 2'b10;
                    state_n  = DONE;
                end else begin
                    p_n     = s1_r;
                    v_n     = s1_r;
                    k_n     = 4'd0;
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                if (p_r == s2_r) begin
                    pos_n    = k_r;
                    val_n    = v_r;
                    status_n = 2'b01;
                    state_n  = DONE;
                end else if (k_r == LAST) begin
                    status_n = 2'b10;
                    state_n  = DONE;
                end else begin
                    p_n = m2_out_s;
                    v_n = gf_mul9(v_r);
                    k_n = k_r + 4'd1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    s1_n     = 4'd0;
                    s2_n     = 4'd0;
                    cnt_n    = 4'd0;
                    status_n = 2'b00;
                    pos_n    = 4'd0;
                    val_n    = 4'd0;
                    state_n  = ACCUM;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = ACCUM;
            end
        endcase
    end

    // State and output registers; handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ACCUM;
            s1_r        <= 4'd0;
            s2_r        <= 4'd0;
            cnt_r       <= 4'd0;
            p_r         <= 4'd0;
            v_r         <= 4'd0;
            k_r         <= 4'd0;
            status_r    <= 2'b00;
            pos_r       <= 4'd0;
            val_r       <= 4'd0;
            sym_ready_r <= 1'b1;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            s1_r        <= s1_n;
            s2_r        <= s2_n;
            cnt_r       <= cnt_n;
            p_r         <= p_n;
            v_r         <= v_n;
            k_r         <= k_n;
            status_r    <= status_n;
            pos_r       <= pos_n;
            val_r       <= val_n;
            sym_ready_r <= (state_n == ACCUM);
            res_valid_r <= (state_n == DONE);
        end
    end

    assign bus.sym_ready  = sym_ready_r;
    assign bus.res_valid  = res_valid_r;
    assign bus.res_status = status_r;
    assign bus.syn1       = s1_r;
    assign bus.syn2       = s2_r;
    assign bus.err_pos    = pos_r;
    assign bus.err_val    = val_r;
endmodule

// File: tb/tb_rs_syndrome_seq.sv
// Scoreboard bench for rs_syndrome_seq: an N=15 and an N=5 instance with directed codewords.
module tb_rs_syndrome_seq;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Edge counter used to measure result latency.
    always @(posedge clk) cyc <= cyc + 1;

    rs_syndrome_seq_if if0 ();
    rs_syndrome_seq_if if1 ();

    rs_syndrome_seq #(.N(15)) dut15 (.clk(clk), .rstn(rstn), .bus(if0));
    rs_syndrome_seq #(.N(5))  dut5  (.clk(clk), .rstn(rstn), .bus(if1));

    logic [1:0] sv = 2'b00;
    logic [1:0] rr = 2'b00;
    logic [3:0] sy [2];
    logic [1:0] rv, srdy;
    logic [1:0] st [2];
    logic [3:0] s1o [2];
    logic [3:0] s2o [2];
    logic [3:0] po [2];
    logic [3:0] vo [2];

    assign if0.sym_valid = sv[0];
    assign if1.sym_valid = sv[1];
    assign if0.sym       = sy[0];
    assign if1.sym       = sy[1];
    assign if0.res_ready = rr[0];
    assign if1.res_ready = rr[1];
    assign rv   = {if1.res_valid, if0.res_valid};
    assign srdy = {if1.sym_ready, if0.sym_ready};
    assign st[0]  = if0.res_status;
    assign st[1]  = if1.res_status;
    assign s1o[0] = if0.syn1;
    assign s1o[1] = if1.syn1;
    assign s2o[0] = if0.syn2;
    assign s2o[1] = if1.syn2;
    assign po[0]  = if0.err_pos;
    assign po[1]  = if1.err_pos;
    assign vo[0]  = if0.err_val;
    assign vo[1]  = if1.err_val;

    typedef struct {
        int         dut;
        logic [1:0] st;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] pos;
        logic [3:0] val;
        int         lat;
        int         t;
        int         hold;
    } exp_t;

    exp_t q[$];
    bit   mon_busy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    // Monitor: pops the expected result when a DUT presents one, checks it, holds, then accepts.
    initial begin
        exp_t e;
        int   d;
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                if (rv != 2'b00) chk("spurious_res_valid", 32'(rv), 32'd0);
                continue;
            end
            e = q[0];
            d = e.dut;
            if (!rv[d]) begin
                if (cyc - e.t > 200) begin
                    chk("res_valid_timeout", 32'd0, 32'd1);
                    void'(q.pop_front());
                end
                continue;
            end
            void'(q.pop_front());
            mon_busy = 1'b1;
            chk("latency", 32'(cyc - e.t), 32'(e.lat));
            chk("status",  32'(st[d]),  32'(e.st));
            chk("syn1",    32'(s1o[d]), 32'(e.s1));
            chk("syn2",    32'(s2o[d]), 32'(e.s2));
            chk("err_pos", 32'(po[d]),  32'(e.pos));
            chk("err_val", 32'(vo[d]),  32'(e.val));
            for (int h = 0; h < e.hold; h++) begin
                @(negedge clk);
                chk("hold_stable", 32'({rv[d], st[d], s1o[d], s2o[d], po[d], vo[d]}),
                    32'({1'b1, e.st, e.s1, e.s2, e.pos, e.val}));
            end
            rr[d] = 1'b1;
            @(posedge clk);
            #1 rr[d] = 1'b0;
            @(negedge clk);
            chk("post_handshake", 32'({srdy[d], rv[d]}), 32'({1'b1, 1'b0}));
            mon_busy = 1'b0;
        end
    end

    task automatic wait_idle();
        int g = 0;
        while ((q.size() != 0 || mon_busy) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Sends `count` symbols of a codeword whose nibble k is the symbol at position k.
    task automatic send(input int d, input int n, input logic [59:0] cw, input bit gaps,
                        input int count, input exp_t e);
        exp_t ee;
        for (int i = 0; i < count; i++) begin
            int k = n - 1 - i;
            int g = 0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                sv[d] = 1'b0;
                @(posedge clk);
            end
            do begin
                @(negedge clk);
                sv[d] = 1'b1;
                sy[d] = cw[4*k +: 4];
                g++;
            end while (!srdy[d] && g < 200);
            if (!srdy[d]) chk("sym_ready_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
            if (i == n - 1) begin
                ee = e;
                ee.t = cyc;
                q.push_back(ee);
            end
        end
        @(negedge clk);
        sv[d] = 1'b0;
    endtask

    task automatic run(input int d, input int n, input logic [59:0] cw, input bit gaps,
                       input logic [1:0] est, input logic [3:0] es1, input logic [3:0] es2,
                       input logic [3:0] epos, input logic [3:0] evl, input int lat, input int hold);
        exp_t e;
        e.dut = d; e.st = est; e.s1 = es1; e.s2 = es2; e.pos = epos; e.val = evl;
        e.lat = lat; e.t = 0; e.hold = hold;
        send(d, n, cw, gaps, n, e);
        wait_idle();
    endtask

    task automatic chk_reset(input int d);
        chk("rst_sym_ready", 32'(srdy[d]), 32'd1);
        chk("rst_res_valid", 32'(rv[d]), 32'd0);
        chk("rst_fields", 32'({st[d], s1o[d], s2o[d], po[d], vo[d]}), 32'd0);
    endtask

    initial begin
        exp_t dummy;
        dummy = '{dut: 0, st: 2'b00, s1: 4'h0, s2: 4'h0, pos: 4'h0, val: 4'h0, lat: 0, t: 0, hold: 0};
        sy[0] = 4'h0;
        sy[1] = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rstn = 1'b1;

        // N=15 directed codewords: {dut, N, codeword, gaps, status, S1, S2, pos, val, latency, hold}
        run(0, 15, 60'h0,                      1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1,  0);
        run(0, 15, {4'h5, 56'h0},              1'b0, 2'b01, 4'hB, 4'hC, 4'hE, 4'h5, 16, 0);
        run(0, 15, 60'h1,                      1'b0, 2'b01, 4'h1, 4'h1, 4'h0, 4'h1, 2,  0);
        run(0, 15, 60'h12,                     1'b0, 2'b10, 4'h0, 4'h6, 4'h0, 4'h0, 1,  0);
        // Errors at k=0 and k=2 alias to a single error of value 1 at k=8.
        run(0, 15, 60'h101,                    1'b0, 2'b01, 4'h5, 4'h2, 4'h8, 4'h1, 10, 0);
        run(0, 15, 60'hA000,                   1'b0, 2'b01, 4'hF, 4'h1, 4'h3, 4'hA, 5,  3);

        // N=5: alias would be k=8, beyond the codeword, so the search runs out.
        run(1, 5, 60'h101,                     1'b0, 2'b10, 4'h5, 4'h2, 4'h0, 4'h0, 6,  0);
        run(1, 5, 60'h10000,                   1'b0, 2'b01, 4'h3, 4'h5, 4'h4, 4'h1, 6,  0);

        // Partial codeword then reset.
        send(0, 15, 60'hFFFFFFFFFFFFFFF, 1'b0, 7, dummy);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset(0);
        rstn = 1'b1;

        run(0, 15, 60'h700000,                 1'b1, 2'b01, 4'h1, 4'h6, 4'h5, 4'h7, 7,  5);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
